// File: rtl/hd_pkg.sv
// Shared types and constants for the load-use hazard / stall controller.
// Optional feature macro used by the top level: STALL_CNT_EN.
package hd_pkg;

  // Controller state: idle, or in the tail of a multi-cycle load-use stall.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LD_STALL = 1'b1
  } hd_state_e;

  // Architectural register 0 is hard-wired to zero and never creates a hazard.
  localparam int REG_ZERO = 0;

  // Pipeline enable set driven by the controller.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic ctrl_pass;
    logic if_id_flush;
    logic pipe_hold;
  } hd_ctrl_t;

  // Free-running pipe: everything advances, nothing is flushed or held.
  localparam hd_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       ctrl_pass: 1'b1, if_id_flush: 1'b0,
                                       pipe_hold: 1'b0};

  // Data memory busy: whole pipe frozen, ID/EX holds its contents (no bubble).
  localparam hd_ctrl_t CTRL_BUSY   = '{pc_write: 1'b0, if_id_write: 1'b0,
                                       ctrl_pass: 1'b1, if_id_flush: 1'b0,
                                       pipe_hold: 1'b1};

  // Load-use stall: PC and IF/ID held, bubble injected into ID/EX.
  localparam hd_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0,
                                       ctrl_pass: 1'b0, if_id_flush: 1'b0,
                                       pipe_hold: 1'b0};

  // Taken branch: fetch continues from the target, wrong-path IF/ID is cleared.
  localparam hd_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       ctrl_pass: 1'b1, if_id_flush: 1'b1,
                                       pipe_hold: 1'b0};

endpackage

// File: rtl/hd_src_match.sv
// Compares one ID-stage source register against the EX-stage load destination.
// A source only matches when the instruction actually reads it and the
// destination is not register 0.
module hd_src_match
  import hd_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_i,
  input  logic              src_valid_i,
  input  logic [ADDR_W-1:0] dest_i,
  output logic              match_o
);

  logic dest_nonzero;

  assign dest_nonzero = (dest_i != ADDR_W'(REG_ZERO));
  assign match_o      = src_valid_i & dest_nonzero & (src_i == dest_i);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detection and pipeline stall/flush control for the ID stage.
// Holds PC and IF/ID for LOAD_LAT cycles on a load-use hazard, freezes the
// whole pipe while data memory is busy, and flushes IF/ID on a taken branch.
// Optional macro STALL_CNT_EN adds a saturating counter of PC-hold cycles.
module hazard_stall_ctrl
  import hd_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_rs_valid_i,
  input  logic              id_rt_valid_i,
  input  logic [ADDR_W-1:0] ex_rt_i,
  input  logic              ex_memread_i,
  input  logic              mem_busy_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              ctrl_pass_o,
  output logic              if_id_flush_o,
  output logic              pipe_hold_o
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  // Counter just wide enough to hold LOAD_LAT-1 remaining stall cycles.
  localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  hd_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rs_hit, rt_hit, hit;
  logic            stall;
  hd_ctrl_t        ctrl;

  hd_src_match #(.ADDR_W(ADDR_W)) u_rs_match (
    .src_i       (id_rs_i),
    .src_valid_i (id_rs_valid_i),
    .dest_i      (ex_rt_i),
    .match_o     (rs_hit)
  );

  hd_src_match #(.ADDR_W(ADDR_W)) u_rt_match (
    .src_i       (id_rt_i),
    .src_valid_i (id_rt_valid_i),
    .dest_i      (ex_rt_i),
    .match_o     (rt_hit)
  );

  assign hit = ex_memread_i & (rs_hit | rt_hit);

  // Stall is immediate on the detection cycle and unconditional in LD_STALL.
  assign stall = (state_q == LD_STALL) | ((state_q == IDLE) & hit);

  // Next-state logic; a busy data memory freezes both state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_busy_i) begin
      unique case (state_q)
        IDLE: begin
          // With a single-cycle latency EX already carries the bubble next
          // cycle, so no extra state is needed.
          if (hit && (LOAD_LAT > 1)) begin
            state_d = LD_STALL;
            cnt_d   = CW'(LOAD_LAT - 1);
          end
        end
        LD_STALL: begin
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and stall counter registers; reset aborts any stall in progress.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output priority: reset, memory busy, load stall, branch flush, normal.
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (!rst_i) begin
      ctrl = CTRL_NORMAL;
    end else if (mem_busy_i) begin
      ctrl = CTRL_BUSY;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end else if (branch_taken_i) begin
      ctrl = CTRL_FLUSH;
    end
  end

  assign pc_write_o    = ctrl.pc_write;
  assign if_id_write_o = ctrl.if_id_write;
  assign ctrl_pass_o   = ctrl.ctrl_pass;
  assign if_id_flush_o = ctrl.if_id_flush;
  assign pipe_hold_o   = ctrl.pipe_hold;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count every cycle the PC is held (load stall or busy), saturating.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (!ctrl.pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl. Two instances (LOAD_LAT=1 and
// LOAD_LAT=3) share one stimulus stream; expected enable sets are pushed to a
// scoreboard when each cycle's inputs are driven and popped at the negedge.
module tb_hazard_stall_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] id_rs, id_rt, ex_rt;
  logic          rs_v, rt_v, memrd, busy, br;
  logic          pcw1, ifw1, cp1, fl1, ph1;
  logic          pcw3, ifw3, cp3, fl3, ph3;
`ifdef STALL_CNT_EN
  logic [CW-1:0] sc1, sc3;
`endif

  hazard_stall_ctrl #(.ADDR_W(AW), .LOAD_LAT(1), .CNT_W(CW)) dut_l1 (
    .clk_i(clk), .rst_i(rst_n),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_valid_i(rs_v), .id_rt_valid_i(rt_v),
    .ex_rt_i(ex_rt), .ex_memread_i(memrd), .mem_busy_i(busy), .branch_taken_i(br),
    .pc_write_o(pcw1), .if_id_write_o(ifw1), .ctrl_pass_o(cp1),
    .if_id_flush_o(fl1), .pipe_hold_o(ph1)
`ifdef STALL_CNT_EN
    , .stall_cnt_o(sc1)
`endif
  );

  hazard_stall_ctrl #(.ADDR_W(AW), .LOAD_LAT(3), .CNT_W(CW)) dut_l3 (
    .clk_i(clk), .rst_i(rst_n),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_valid_i(rs_v), .id_rt_valid_i(rt_v),
    .ex_rt_i(ex_rt), .ex_memread_i(memrd), .mem_busy_i(busy), .branch_taken_i(br),
    .pc_write_o(pcw3), .if_id_write_o(ifw3), .ctrl_pass_o(cp3),
    .if_id_flush_o(fl3), .pipe_hold_o(ph3)
`ifdef STALL_CNT_EN
    , .stall_cnt_o(sc3)
`endif
  );

  // Expected enable vectors are {pc_write, if_id_write, ctrl_pass, flush, hold}.
  typedef struct {
    logic [4:0] e1;
    logic [4:0] e3;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m1 = 0, m3 = 0;        // remaining stall cycles in each reference model
  int   cnt1 = 0, cnt3 = 0;    // reference PC-hold cycle counts
  int   tally1 = 0, tally3 = 0; // observed PC-hold cycles in the current test

  function automatic logic hit_f();
    return memrd && (ex_rt != 0) &&
           ((rs_v && (id_rs == ex_rt)) || (rt_v && (id_rt == ex_rt)));
  endfunction

  function automatic logic [4:0] exp_f(input int m);
    if (busy)             return 5'b00101;
    if (m > 0 || hit_f()) return 5'b00000;
    if (br)               return 5'b11110;
    return 5'b11100;
  endfunction

  function automatic int next_m(input int m, input int lat);
    if (busy)    return m;
    if (m > 0)   return m - 1;
    if (hit_f()) return lat - 1;
    return 0;
  endfunction

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    rs_v = 1'b0; rt_v = 1'b0; memrd = 1'b0; busy = 1'b0; br = 1'b0;
  endtask

  task automatic set_load(input logic [AW-1:0] dst);
    memrd = 1'b1;
    ex_rt = dst;
  endtask

  // One clock cycle: push expectation, compare at negedge, advance the models.
  task automatic step(input string tag);
    exp_t       e;
    logic [4:0] a1, a3;
    e.e1  = exp_f(m1);
    e.e3  = exp_f(m3);
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    e  = sb.pop_front();
    a1 = {pcw1, ifw1, cp1, fl1, ph1};
    a3 = {pcw3, ifw3, cp3, fl3, ph3};
    $display("%0t %s l1=%b (exp %b) l3=%b (exp %b)", $time, e.tag, a1, e.e1, a3, e.e3);
    checks++;
    if (a1 !== e.e1) begin
      errors++;
      $display("FAIL %s lat1 enables: got %b expected %b", e.tag, a1, e.e1);
    end
    checks++;
    if (a3 !== e.e3) begin
      errors++;
      $display("FAIL %s lat3 enables: got %b expected %b", e.tag, a3, e.e3);
    end
`ifdef STALL_CNT_EN
    checks++;
    if (sc1 !== CW'(cnt1)) begin
      errors++;
      $display("FAIL %s lat1 stall_cnt: got %0d expected %0d", e.tag, sc1, cnt1);
    end
    checks++;
    if (sc3 !== CW'(cnt3)) begin
      errors++;
      $display("FAIL %s lat3 stall_cnt: got %0d expected %0d", e.tag, sc3, cnt3);
    end
`endif
    if (a1[4] === 1'b0) tally1++;
    if (a3[4] === 1'b0) tally3++;
    if (!e.e1[4]) cnt1++;
    if (!e.e3[4]) cnt3++;
    m1 = next_m(m1, 1);
    m3 = next_m(m3, 3);
    @(posedge clk);
    #1;
  endtask

  task automatic check_tally(input string tag, input int exp1, input int exp3);
    checks++;
    if (tally1 != exp1) begin
      errors++;
      $display("FAIL %s lat1 hold cycles: got %0d expected %0d", tag, tally1, exp1);
    end
    checks++;
    if (tally3 != exp3) begin
      errors++;
      $display("FAIL %s lat3 hold cycles: got %0d expected %0d", tag, tally3, exp3);
    end
    tally1 = 0;
    tally3 = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({pcw1, ifw1, cp1, fl1, ph1} !== 5'b11100) begin
      errors++;
      $display("FAIL %s lat1 in reset: got %b expected 11100", tag, {pcw1, ifw1, cp1, fl1, ph1});
    end
    checks++;
    if ({pcw3, ifw3, cp3, fl3, ph3} !== 5'b11100) begin
      errors++;
      $display("FAIL %s lat3 in reset: got %b expected 11100", tag, {pcw3, ifw3, cp3, fl3, ph3});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check_reset_outputs("reset_idle");
    // A hazard present while reset is held must not stall.
    set_load(5'd8); id_rs = 5'd8; rs_v = 1'b1; br = 1'b1;
    #1;
    check_reset_outputs("reset_hazard");
`ifdef STALL_CNT_EN
    checks++;
    if (sc3 !== '0) begin
      errors++;
      $display("FAIL reset stall_cnt: got %0d expected 0", sc3);
    end
`endif
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    m1 = 0; m3 = 0; cnt1 = 0; cnt3 = 0;
    @(posedge clk);
    #1;
    step("after_reset");
    tally1 = 0; tally3 = 0;
  endtask

  task automatic test_load_use();
    set_load(5'd8); id_rs = 5'd8; rs_v = 1'b1;
    step("lu_detect");
    idle_inputs();
    for (int i = 0; i < 4; i++) step("lu_tail");
    check_tally("load_use_rs", 1, 3);
`ifdef STALL_CNT_EN
    checks++;
    if (sc3 !== CW'(3)) begin
      errors++;
      $display("FAIL lu stall_cnt lat3: got %0d expected 3", sc3);
    end
`endif
    // Hazard through rt instead of rs.
    set_load(5'd17); id_rt = 5'd17; rt_v = 1'b1; id_rs = 5'd3; rs_v = 1'b1;
    step("lu_rt_detect");
    idle_inputs();
    for (int i = 0; i < 3; i++) step("lu_rt_tail");
    check_tally("load_use_rt", 1, 3);
  endtask

  task automatic test_no_hazard();
    // rt matches but is not read by the ID instruction.
    set_load(5'd8); id_rt = 5'd8; rt_v = 1'b0; id_rs = 5'd9; rs_v = 1'b1;
    step("rt_invalid");
    // Register 0 never creates a hazard.
    set_load(5'd0); id_rs = 5'd0; rs_v = 1'b1; id_rt = 5'd0; rt_v = 1'b1;
    step("reg_zero");
    // Matching register but EX is not a load.
    idle_inputs(); ex_rt = 5'd12; id_rs = 5'd12; rs_v = 1'b1;
    step("no_load");
    idle_inputs();
    step("quiet");
    check_tally("no_hazard", 0, 0);
  endtask

  task automatic test_busy_in_stall();
    set_load(5'd4); id_rt = 5'd4; rt_v = 1'b1;
    step("busy_detect");
    idle_inputs(); busy = 1'b1;
    step("busy_1");
    step("busy_2");
    busy = 1'b0;
    for (int i = 0; i < 3; i++) step("busy_resume");
    check_tally("busy_span", 3, 5);
    // Busy in IDLE masks a hazard that cycle.
    set_load(5'd6); id_rs = 5'd6; rs_v = 1'b1; busy = 1'b1; br = 1'b1;
    step("busy_masks_hit");
    idle_inputs();
    step("busy_after");
    check_tally("busy_idle", 1, 1);
  endtask

  task automatic test_branch();
    set_load(5'd10); id_rs = 5'd10; rs_v = 1'b1; br = 1'b1;
    step("br_with_hazard");
    idle_inputs(); br = 1'b1;
    for (int i = 0; i < 3; i++) step("br_after_stall");
    br = 1'b1;
    step("br_alone");
    idle_inputs();
    step("br_clear");
    check_tally("branch", 1, 3);
  endtask

  task automatic test_back_to_back();
    set_load(5'd20); id_rs = 5'd20; rs_v = 1'b1;
    step("b2b_1");
    set_load(5'd21); id_rt = 5'd21; rt_v = 1'b1; id_rs = 5'd2;
    step("b2b_2");
    idle_inputs();
    for (int i = 0; i < 3; i++) step("b2b_tail");
    check_tally("back_to_back", 2, 3);
  endtask

  task automatic test_reset_mid_stall();
    set_load(5'd8); id_rs = 5'd8; rs_v = 1'b1;
    step("mid_detect");
    // Lat-3 instance is now in LD_STALL; reset asynchronously.
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid_reset");
    idle_inputs();
    m1 = 0; m3 = 0; cnt1 = 0; cnt3 = 0;
    #1;
`ifdef STALL_CNT_EN
    checks++;
    if (sc3 !== '0) begin
      errors++;
      $display("FAIL mid_reset stall_cnt: got %0d expected 0", sc3);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_reset");
    step("post_reset2");
    tally1 = 0; tally3 = 0;
    set_load(5'd8); id_rs = 5'd8; rs_v = 1'b1;
    step("cnt_detect");
    idle_inputs();
    for (int i = 0; i < 3; i++) step("cnt_tail");
    check_tally("after_mid_reset", 1, 3);
`ifdef STALL_CNT_EN
    checks++;
    if (sc3 !== CW'(3)) begin
      errors++;
      $display("FAIL single stall stall_cnt lat3: got %0d expected 3", sc3);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_busy_in_stall();
    test_branch();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised successor of the pipeline hazard detection unit for the 5-stage MIPS core. It detects load-use hazards between the ID-stage source registers and a load in EX, and holds PC and IF/ID for a configurable number of cycles (multi-cycle data memory). It also inserts an ID/EX bubble, freezes the whole pipe on data-memory busy, and flushes IF/ID on a taken branch. Sits in ID; drives the PC, IF/ID and ID/EX control mux enables.

Parameters:
ADDR_W, 5, register address width
LOAD_LAT, 1, load-use stall cycles (>=1); 1 = classic single-bubble behaviour
CNT_W, 32, stall counter width (only with STALL_CNT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
id_rs_i  in  ADDR_W  ID source register 1
id_rt_i  in  ADDR_W  ID source register 2
id_rs_valid_i  in  1  instruction in ID reads rs
id_rt_valid_i  in  1  instruction in ID reads rt
ex_rt_i  in  ADDR_W  destination of instruction in EX
ex_memread_i  in  1  instruction in EX is a load
mem_busy_i  in  1  data memory not ready this cycle
branch_taken_i  in  1  branch resolved taken in ID
pc_write_o  out  1  1 = PC updates, 0 = hold
if_id_write_o  out  1  1 = IF/ID loads, 0 = hold
ctrl_pass_o  out  1  1 = ID controls pass to ID/EX, 0 = zero (bubble)
if_id_flush_o  out  1  1 = IF/ID cleared next edge
pipe_hold_o  out  1  1 = ID/EX, EX/MEM, MEM/WB hold
stall_cnt_o  out  CNT_W  stall cycle count (STALL_CNT_EN only)

Behaviour:
- hit (combinational) = ex_memread_i & (ex_rt_i != 0) & ((id_rs_valid_i & id_rs_i==ex_rt_i) | (id_rt_valid_i & id_rt_i==ex_rt_i)). Register 0 never hazards.
- FSM states: IDLE, LD_STALL. Down-counter cnt, width clog2(LOAD_LAT+1).
- IDLE, hit, !mem_busy_i: stall this cycle. If LOAD_LAT>1: next = LD_STALL, cnt = LOAD_LAT-1. If LOAD_LAT==1: stay IDLE (EX holds the bubble next cycle, so no re-hit).
- LD_STALL: stall asserted unconditionally; cnt decrements each non-busy cycle; at cnt==1 -> IDLE on that edge. Total stall = LOAD_LAT cycles.
- Stall outputs: pc_write_o=0, if_id_write_o=0, ctrl_pass_o=0, if_id_flush_o=0.
- mem_busy_i=1 (highest priority): pc_write_o=0, if_id_write_o=0, pipe_hold_o=1, ctrl_pass_o=1 (no bubble, ID/EX held), flush=0. FSM state and cnt frozen. hit ignored in IDLE that cycle.
- branch_taken_i with no stall and no busy: if_id_flush_o=1, pc/if_id write = 1.
- Branch together with a stall: flush suppressed; ID is held, so the branch re-resolves after the stall.
- Priority: mem_busy > load stall > branch flush > normal (all enables 1, flush 0, hold 0).
- Reset (rst_i=0, async): state IDLE, cnt 0, stall_cnt 0. Outputs while in reset: pc_write_o=1, if_id_write_o=1, ctrl_pass_o=1, if_id_flush_o=0, pipe_hold_o=0.
- Reset mid-LD_STALL aborts the stall immediately.
- Outputs are combinational from state plus inputs: zero-latency stall on the detection cycle.

Optional Feature:
STALL_CNT_EN: defined -> CNT_W register counts cycles with pc_write_o==0 (load stall or busy), saturating at all-ones, cleared by reset, driven on stall_cnt_o. Undefined -> port absent, no counter logic.

Decomposition:
- Package hd_pkg: state enum (IDLE, LD_STALL), REG_ZERO constant, output-bundle struct for the enable set.
- One sub-module, hd_src_match: per-source comparator (addr, valid, dest, zero check) instantiated twice.

Test Plan:
- LOAD_LAT=1; ex_memread=1, ex_rt=8, id_rs=8 valid -> one cycle pc_write=0, ctrl_pass=0; next cycle all enables 1.
- LOAD_LAT=3, same hazard -> exactly 3 consecutive stall cycles, then IDLE; id_rt=8 with id_rt_valid=0 -> no stall.
- ex_rt=0, id_rs=0, load in EX -> no stall.
- LOAD_LAT=3, mem_busy=1 for 2 cycles during the 2nd stall cycle -> pipe_hold=1, ctrl_pass=1; total pc_write=0 span = 5 cycles.
- Hazard plus branch_taken same cycle -> flush=0, stall; branch alone -> flush=1, pc_write=1.
- rst_i low during LD_STALL -> IDLE, enables 1; with STALL_CNT_EN, stall_cnt_o=0 after reset, =3 after one LOAD_LAT=3 stall.
